// File: rtl/mod30_counter_pkg.sv
// mod30_counter_pkg: shared sizing constants for the modulo-30 counter.
package mod30_counter_pkg;
    localparam int MOD30_MODULUS = 30;
    localparam int MOD30_WIDTH   = 5;
endpackage

// File: rtl/mod30_counter_core.sv
// mod30_counter_core: generic modulo-N up-counter with terminal-count decode.
import mod30_counter_pkg::*;

module mod30_counter_core #(
    parameter int MODULUS = MOD30_MODULUS,
    parameter int WIDTH   = MOD30_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic             tc
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_params
        $error("mod30_counter_core: MODULUS must be in 2..2**WIDTH");
    end
    // >= rather than == so any illegal value falls back to 0 on the next edge
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else q <= (q >= LAST) ? '0 : q + WIDTH'(1);
    end
    assign tc = (q == LAST);
endmodule

// File: rtl/mod30_counter.sv
// mod30_counter: free-running divide-by-30 counter with terminal-count flag.
import mod30_counter_pkg::*;

module mod30_counter (
    input  logic                   clk,
    input  logic                   rst,
    output logic [MOD30_WIDTH-1:0] q,
    output logic                   tc
);
    mod30_counter_core #(
        .MODULUS(MOD30_MODULUS),
        .WIDTH  (MOD30_WIDTH)
    ) u_core (
        .clk(clk),
        .rst(rst),
        .q  (q),
        .tc (tc)
    );
endmodule

// File: tb/tb_mod30_counter.sv
// tb_mod30_counter: vector table, directed corners and randomized run against a modulo model.
module tb_mod30_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] q;
    logic       tc;
    int checks = 0;
    int errors = 0;
    int m = 0;
    typedef struct {
        logic rst;
        int   q;
        logic tc;
    } vec_t;
    vec_t tbl[12];

    mod30_counter dut (.clk(clk), .rst(rst), .q(q), .tc(tc));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r);
        @(negedge clk);
        rst = r;
        @(posedge clk);
        #1;
        m = r ? 0 : (m + 1) % 30;
    endtask

    task automatic step_chk(input logic r, input string name);
        step(r);
        chk({name, "_q"}, int'(q), m);
        chk({name, "_tc"}, int'(tc), int'(m == 29));
    endtask

    initial begin
        int tc_seen;
        int tc_exp;
        int guard;
        tbl[0]  = '{1'b1, 0, 1'b0};
        tbl[1]  = '{1'b1, 0, 1'b0};
        tbl[2]  = '{1'b0, 1, 1'b0};
        tbl[3]  = '{1'b0, 2, 1'b0};
        tbl[4]  = '{1'b0, 3, 1'b0};
        tbl[5]  = '{1'b1, 0, 1'b0};
        tbl[6]  = '{1'b0, 1, 1'b0};
        tbl[7]  = '{1'b0, 2, 1'b0};
        tbl[8]  = '{1'b1, 0, 1'b0};
        tbl[9]  = '{1'b1, 0, 1'b0};
        tbl[10] = '{1'b0, 1, 1'b0};
        tbl[11] = '{1'b0, 2, 1'b0};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst);
            chk($sformatf("vec%0d_q", i), int'(q), tbl[i].q);
            chk($sformatf("vec%0d_tc", i), int'(tc), int'(tbl[i].tc));
        end

        step_chk(1'b1, "reset_again");
        for (int i = 0; i < 50; i++) step_chk(1'b0, "free_run");

        guard = 0;
        while ($time < 500 && guard < 200) begin
            step_chk(1'b0, "pre_mid");
            guard++;
        end
        chk("mid_not_zero", int'(q != 0), 1);
        step_chk(1'b1, "mid_reset");
        step_chk(1'b0, "mid_resume1");
        step_chk(1'b0, "mid_resume2");

        guard = 0;
        while (m != 29 && guard < 40) begin
            step_chk(1'b0, "to_tc");
            guard++;
        end
        chk("at_tc_flag", int'(tc), 1);
        step_chk(1'b1, "reset_at_tc");
        step_chk(1'b0, "after_tc_reset");

        tc_seen = 0;
        tc_exp = 0;
        for (int i = 0; i < 420; i++) begin
            step(1'b0);
            if (tc) tc_seen++;
            if (m == 29) tc_exp++;
            if (q >= 5'd30 || int'(q) != m) chk("long_run_q", int'(q), m);
        end
        chk("long_run_tc_count", tc_seen, tc_exp);
        chk("long_run_tc_floor", int'(tc_exp >= 13 && tc_exp <= 15), 1);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 24) == 0);
            if (int'(q) != m || tc !== (m == 29)) begin
                chk("rand_q", int'(q), m);
                chk("rand_tc", int'(tc), int'(m == 29));
            end else checks++;
        end

        step_chk(1'b1, "pre_force");
        @(negedge clk);
        rst = 1'b0;
        force dut.u_core.q = 5'd30;
        #1;
        release dut.u_core.q;
        chk("illegal30_tc", int'(tc), 0);
        @(posedge clk);
        #1;
        m = 0;
        chk("recover30_q", int'(q), 0);
        step_chk(1'b0, "recover30_next");
        @(negedge clk);
        force dut.u_core.q = 5'd31;
        #1;
        release dut.u_core.q;
        @(posedge clk);
        #1;
        m = 0;
        chk("recover31_q", int'(q), 0);
        step_chk(1'b0, "recover31_next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
